// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider with shadowed, boundary-applied config.
// Optional macro CLK_DIV_SYNC_EN adds sync_i, a phase-align strobe for all enabled channels.

module clk_div_lane #(
  parameter int WIDTH   = 32,
  parameter int DEF_DIV = 200
) (
  input  logic             clk0,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             we,
  input  logic [WIDTH-1:0] wdiv,
  input  logic [WIDTH-1:0] whigh,
  output logic             pend,
  output logic             clk_out,
  output logic             tick
);
  localparam logic [WIDTH-1:0] DEF_D = WIDTH'(DEF_DIV);
  localparam logic [WIDTH-1:0] DEF_H = DEF_D >> 1;
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] cnt, div_act, high_act, div_sh, high_sh;
  logic [WIDTH-1:0] cnt_nx, div_nx, high_nx, cnt_inc;
  logic             wrap, restart, apply, clk_nx, tick_nx;

  always_comb begin
    cnt_inc = cnt + ONE;
    wrap    = (cnt == div_act - ONE);
    restart = en & (wrap | sync);
    // Shadow only moves at a period boundary or while parked, so no runt pulses.
    apply   = pend & (restart | ~en);
    div_nx  = apply ? div_sh  : div_act;
    high_nx = apply ? high_sh : high_act;
    cnt_nx  = cnt_inc;
    clk_nx  = (cnt_inc < high_act);
    tick_nx = 1'b0;
    if (!en) begin
      cnt_nx  = div_nx - ONE;
      clk_nx  = 1'b0;
    end else if (restart) begin
      cnt_nx  = '0;
      clk_nx  = (high_nx != '0);
      tick_nx = (high_nx != '0);
    end
  end

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= DEF_D - ONE;
      div_act  <= DEF_D;
      high_act <= DEF_H;
      div_sh   <= DEF_D;
      high_sh  <= DEF_H;
      pend     <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      cnt      <= cnt_nx;
      div_act  <= div_nx;
      high_act <= high_nx;
      clk_out  <= clk_nx;
      tick     <= tick_nx;
      pend     <= we | (pend & ~apply);
      if (we) begin
        div_sh  <= wdiv;
        high_sh <= whigh;
      end
    end
  end
endmodule

module clk_div_prog #(
  parameter  int NUM_CH  = 4,
  parameter  int WIDTH   = 32,
  parameter  int DEF_DIV = 200,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk0,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]  cfg_div,
  input  logic [WIDTH-1:0]  cfg_high,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] cfg_pend,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
`ifdef CLK_DIV_SYNC_EN
  ,
  input  logic              sync_i
`endif
);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

  logic              ch_bad, div_bad, wr_ok, sync;
  logic [WIDTH-1:0]  high_w;
  logic [NUM_CH-1:0] we_ch;

`ifdef CLK_DIV_SYNC_EN
  assign sync = sync_i;
`else
  assign sync = 1'b0;
`endif

  // A power-of-two channel count leaves no out-of-range cfg_ch encodings.
  generate
    if ((1 << CH_W) == NUM_CH) begin : g_ch_full
      assign ch_bad = 1'b0;
    end else begin : g_ch_part
      assign ch_bad = (cfg_ch >= CH_W'(NUM_CH));
    end
  endgenerate

  assign div_bad = (cfg_div < TWO);
  assign wr_ok   = cfg_we & ~ch_bad & ~div_bad;

  always_comb begin
    high_w = cfg_high;
    if (cfg_high == '0)          high_w = cfg_div >> 1;
    else if (cfg_high >= cfg_div) high_w = cfg_div - WIDTH'(1);
  end

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) cfg_err <= 1'b0;
    else        cfg_err <= cfg_we & (ch_bad | div_bad);
  end

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
      assign we_ch[g] = wr_ok & (cfg_ch == CH_W'(g));
      clk_div_lane #(.WIDTH(WIDTH), .DEF_DIV(DEF_DIV)) u_lane (
        .clk0    (clk0),
        .rst_n   (rst_n),
        .en      (ch_en[g]),
        .sync    (sync),
        .we      (we_ch[g]),
        .wdiv    (cfg_div),
        .whigh   (high_w),
        .pend    (cfg_pend[g]),
        .clk_out (clk_out[g]),
        .tick    (tick[g])
      );
    end
  endgenerate
endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed tables/sequences plus randomized run against a per-channel model.
module tb_clk_div_prog;
  logic        clk0 = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  ch_en = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [31:0] cfg_div = '0, cfg_high = '0;
  logic        cfg_err;
  logic [3:0]  cfg_pend, clk_out, tick;
  logic        sync_i = 1'b0;

  logic [2:0]  b_en = '0;
  logic        b_we = 1'b0;
  logic [1:0]  b_ch = '0;
  logic [31:0] b_div = '0, b_high = '0;
  logic        b_err;
  logic [2:0]  b_pend, b_clk, b_tick;

  int checks = 0, errors = 0;

  always #5 clk0 = ~clk0;

  clk_div_prog u_dut (
    .clk0(clk0), .rst_n(rst_n), .ch_en(ch_en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_err(cfg_err), .cfg_pend(cfg_pend),
    .clk_out(clk_out), .tick(tick)
`ifdef CLK_DIV_SYNC_EN
    , .sync_i(sync_i)
`endif
  );

  clk_div_prog #(.NUM_CH(3), .DEF_DIV(4)) u_dut3 (
    .clk0(clk0), .rst_n(rst_n), .ch_en(b_en), .cfg_we(b_we), .cfg_ch(b_ch),
    .cfg_div(b_div), .cfg_high(b_high), .cfg_err(b_err), .cfg_pend(b_pend),
    .clk_out(b_clk), .tick(b_tick)
`ifdef CLK_DIV_SYNC_EN
    , .sync_i(1'b0)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk0);
    #1;
  endtask

  // One full period of channel ch, measured tick to tick.
  task automatic measure(input int ch, output int per, output int hi);
    int n;
    per = 0; hi = 0;
    for (n = 0; n < 600; n++) begin
      cyc();
      if (tick[ch]) break;
    end
    if (n == 600) return;
    per = 1; hi = int'(clk_out[ch]);
    for (int m = 0; m < 600; m++) begin
      cyc();
      if (tick[ch]) break;
      per++;
      hi += int'(clk_out[ch]);
    end
  endtask

  // Reference model: position within the period plus active/shadow settings.
  int m_ph[4], m_div[4], m_hi[4], m_shd[4], m_shh[4];
  bit m_pv[4];
  logic [3:0] e_clk, e_tick, e_pend;
  logic       e_err;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_div[i] = 200; m_hi[i] = 100; m_ph[i] = 199; m_pv[i] = 0;
    end
    e_clk = '0; e_tick = '0; e_pend = '0; e_err = 0;
  endtask

  task automatic model_step(input logic [3:0] en, input logic we, input int ch,
                            input int d, input int h, input logic sy);
    for (int i = 0; i < 4; i++) begin
      bit boundary;
      boundary = !en[i] || sy || (m_ph[i] == m_div[i] - 1);
      if (boundary && m_pv[i]) begin
        m_div[i] = m_shd[i]; m_hi[i] = m_shh[i]; m_pv[i] = 0;
      end
      if (!en[i]) begin
        m_ph[i] = m_div[i] - 1; e_clk[i] = 0; e_tick[i] = 0;
      end else begin
        m_ph[i] = boundary ? 0 : m_ph[i] + 1;
        e_clk[i]  = (m_ph[i] < m_hi[i]);
        e_tick[i] = (m_ph[i] == 0);
      end
    end
    e_err = we && (d < 2);
    if (we && d >= 2) begin
      m_shd[ch] = d;
      m_shh[ch] = (h == 0) ? d / 2 : ((h < d) ? h : d - 1);
      m_pv[ch]  = 1;
    end
    for (int i = 0; i < 4; i++) e_pend[i] = m_pv[i];
  endtask

  typedef struct {int div; int high; bit err; int per; int hi;} vec_t;
  vec_t tbl[8];

  initial begin
    int per, hi, k;
    tbl[0] = '{6, 9, 1'b0, 6, 5};
    tbl[1] = '{1, 3, 1'b1, 6, 5};
    tbl[2] = '{10, 0, 1'b0, 10, 5};
    tbl[3] = '{0, 0, 1'b1, 10, 5};
    tbl[4] = '{7, 0, 1'b0, 7, 3};
    tbl[5] = '{2, 1, 1'b0, 2, 1};
    tbl[6] = '{3, 2, 1'b0, 3, 2};
    tbl[7] = '{5, 5, 1'b0, 5, 4};

    // Reset state
    ch_en = 4'b0001;
    #22;
    chk("rst_clk", clk_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_pend", cfg_pend, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_b_pend", b_pend, 0);
    @(negedge clk0) rst_n = 1'b1;

    measure(0, per, hi);
    chk("def_per", per, 200);
    chk("def_hi", hi, 100);
    chk("idle_clk", clk_out[3:1], 0);

    // ch1 div=4 high=1 written while parked, then enabled
    cfg_we = 1; cfg_ch = 1; cfg_div = 4; cfg_high = 1;
    cyc();
    cfg_we = 0;
    chk("pend_set", cfg_pend[1], 1);
    cyc();
    chk("pend_apply_parked", cfg_pend[1], 0);
    ch_en = 4'b0011;
    for (int n = 0; n < 8; n++) begin
      cyc();
      chk("div4_clk", clk_out[1], (n % 4) == 0);
      chk("div4_tick", tick[1], (n % 4) == 0);
    end

    // Table: config writes on running ch1
    foreach (tbl[v]) begin
      cfg_we = 1; cfg_ch = 1; cfg_div = tbl[v].div; cfg_high = tbl[v].high;
      cyc();
      cfg_we = 0;
      chk("tbl_err", cfg_err, tbl[v].err);
      chk("tbl_pend", cfg_pend[1], !tbl[v].err);
      cyc();
      chk("tbl_err_pulse", cfg_err, 0);
      for (int n = 0; n < 50 && cfg_pend[1]; n++) cyc();
      chk("tbl_apply", cfg_pend[1], 0);
      measure(1, per, hi);
      chk("tbl_per", per, tbl[v].per);
      chk("tbl_hi", hi, tbl[v].hi);
    end

    // Mid-period write on ch0 must not disturb the current 200-cycle period
    for (int n = 0; n < 250 && !tick[0]; n++) cyc();
    cfg_ch = 0; cfg_div = 10; cfg_high = 0;
    for (k = 1; k <= 300; k++) begin
      cfg_we = (k == 50);
      cyc();
      if (tick[0]) break;
    end
    cfg_we = 0;
    chk("mid_write_period", k, 200);
    chk("mid_write_applied", cfg_pend[0], 0);
    measure(0, per, hi);
    chk("new_per", per, 10);
    chk("new_hi", hi, 5);

    // Drop enable mid-high, then re-enable
    for (int n = 0; n < 20 && !tick[0]; n++) cyc();
    cyc(); cyc();
    chk("still_high", clk_out[0], 1);
    ch_en[0] = 0;
    cyc();
    chk("dis_out", {clk_out[0], tick[0]}, 2'b00);
    cyc(); cyc();
    chk("dis_hold", {clk_out[0], tick[0]}, 2'b00);
    ch_en[0] = 1;
    cyc();
    chk("reen_out", {clk_out[0], tick[0]}, 2'b11);

    // Out-of-range channel on 3-channel instance
    b_we = 1; b_ch = 3; b_div = 5;
    cyc();
    chk("b_badch_err", b_err, 1);
    chk("b_badch_pend", b_pend, 0);
    b_ch = 2;
    cyc();
    b_we = 0;
    chk("b_goodch_err", b_err, 0);
    chk("b_goodch_pend", b_pend, 3'b100);
    chk("b_clk_idle", b_clk | b_tick, 0);

    // Randomized run against the model
    #2 rst_n = 0;
    ch_en = 4'($urandom_range(0, 15));
    cyc(); cyc();
    rst_n = 1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      cfg_we   = ($urandom_range(0, 3) == 0);
      cfg_ch   = 2'($urandom_range(0, 3));
      cfg_div  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 12);
      cfg_high = $urandom_range(0, 15);
      if ($urandom_range(0, 15) == 0) ch_en[$urandom_range(0, 3)] ^= 1'b1;
`ifdef CLK_DIV_SYNC_EN
      sync_i = ($urandom_range(0, 49) == 0);
`endif
      @(posedge clk0);
      model_step(ch_en, cfg_we, int'(cfg_ch), int'(cfg_div), int'(cfg_high), sync_i);
      #1;
      chk("rnd_clk", clk_out, e_clk);
      chk("rnd_tick", tick, e_tick);
      chk("rnd_pend", cfg_pend, e_pend);
      chk("rnd_err", cfg_err, e_err);
    end
    cfg_we = 0; sync_i = 0; ch_en = 4'b1111;
    for (int n = 0; n < 5; n++) cyc();

    // Asynchronous reset takes effect without a clock edge
    #2 rst_n = 0;
    #1;
    chk("async_rst_clk", clk_out, 0);
    chk("async_rst_tick", tick, 0);
    chk("async_rst_pend", cfg_pend, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
